// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves at most STEP bit positions per clock.
// Start/done handshake; ready in IDLE, busy in SHIFT/DONE, result registered on out.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, shifted, sra_v;
    logic [2:0]       op_r, op_nxt;
    logic [SHW-1:0]   rem, rem_nxt, k;
    logic [SHW:0]     back;
    logic [WIDTH-1:0] out_r;

    // k never exceeds rem, so truncating STEP_W is safe whenever it is selected
    always_comb begin
        k    = ({1'b0, rem} > STEP_W) ? STEP_W[SHW-1:0] : rem;
        back = WIDTH_W - {1'b0, k};
        sra_v = $signed(acc) >>> k;
        case (op_r)
            OP_SLL:  shifted = acc << k;
            OP_SRL:  shifted = acc >> k;
            OP_SRA:  shifted = sra_v;
            OP_ROL:  shifted = (acc << k) | (acc >> back);
            OP_ROR:  shifted = (acc >> k) | (acc << back);
            default: shifted = acc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        op_nxt    = op_r;
        rem_nxt   = rem;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nxt   = a;
                    op_nxt    = op;
                    rem_nxt   = amt;
                    state_nxt = (amt != '0 && op <= OP_ROR) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                acc_nxt = shifted;
                rem_nxt = rem - k;
                if (rem == k) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // out is loaded on the edge entering DONE so it is valid during the done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            op_r  <= '0;
            rem   <= '0;
            out_r <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            op_r  <= op_nxt;
            rem   <= rem_nxt;
            if (state_nxt == S_DONE && state != S_DONE) out_r <= acc_nxt;
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign out   = out_r;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: a 32-bit/STEP=4 unit and a 36-bit/STEP=1 unit
// sharing one clock; expected results and latencies are hand-computed constants.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;

    logic        start0, ready0, busy0, done0;
    logic [2:0]  op0;
    logic [31:0] a0, out0;
    logic [4:0]  amt0;

    logic        start1, ready1, busy1, done1;
    logic [2:0]  op1;
    logic [35:0] a1, out1;
    logic [5:0]  amt1;

    int total = 0;
    int bad   = 0;

    iter_shifter #(.WIDTH(32), .STEP(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .a(a0), .amt(amt0),
        .ready(ready0), .busy(busy0), .done(done0), .out(out0)
    );

    iter_shifter #(.WIDTH(36), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .amt(amt1),
        .ready(ready1), .busy(busy1), .done(done1), .out(out1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int u);
        return (u == 0) ? done0 : done1;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_ready(input int u);
        return (u == 0) ? ready0 : ready1;
    endfunction

    function automatic logic [63:0] get_out(input int u);
        return (u == 0) ? {32'h0, out0} : {28'h0, out1};
    endfunction

    task automatic set_start(input int u, input logic v);
        if (u == 0) start0 = v; else start1 = v;
    endtask

    // Run one job; poke>0 re-pulses start during that cycle of the job
    task automatic run_job(input string tag, input int u, input logic [2:0] op,
                           input logic [63:0] a, input logic [7:0] amt,
                           input logic [63:0] exp, input int lat, input int poke);
        int got = 0;
        int ndone = 0;
        int nbusy = 0;
        @(negedge clk);
        if (u == 0) begin
            op0 = op; a0 = a[31:0]; amt0 = amt[4:0];
        end else begin
            op1 = op; a1 = a[35:0]; amt1 = amt[5:0];
        end
        set_start(u, 1'b1);
        check({tag, ".ready"}, {63'h0, get_ready(u)}, 64'h1);
        @(posedge clk);
        #1 set_start(u, 1'b0);
        for (int c = 1; c <= lat + 5; c++) begin
            @(negedge clk);
            if (poke > 0 && c == poke) set_start(u, 1'b1);
            if (poke > 0 && c == poke + 1) set_start(u, 1'b0);
            if (get_busy(u)) nbusy++;
            if (get_done(u)) begin
                ndone++;
                if (got == 0) begin
                    got = c;
                    check({tag, ".out"}, get_out(u), exp);
                end
            end
        end
        check({tag, ".lat"}, 64'(got), 64'(lat));
        check({tag, ".ndone"}, 64'(ndone), 64'h1);
        check({tag, ".busy_cycles"}, 64'(nbusy), 64'(lat));
        check({tag, ".hold"}, get_out(u), exp);
    endtask

    initial begin
        int got;
        int ndone;
        rst_n  = 1'b0;
        start0 = 1'b0; op0 = '0; a0 = '0; amt0 = '0;
        start1 = 1'b0; op1 = '0; a1 = '0; amt1 = '0;
        repeat (3) @(negedge clk);
        check("rst.ready0", {63'h0, ready0}, 64'h1);
        check("rst.busy0",  {63'h0, busy0},  64'h0);
        check("rst.done0",  {63'h0, done0},  64'h0);
        check("rst.out0",   {32'h0, out0},   64'h0);
        check("rst.ready1", {63'h0, ready1}, 64'h1);
        check("rst.out1",   {28'h0, out1},   64'h0);
        rst_n = 1'b1;

        run_job("sll31",   0, 3'b000, 64'h0000_0001, 8'd31, 64'h8000_0000, 9, 0);
        run_job("sra4",    0, 3'b010, 64'h8000_0000, 8'd4,  64'hF800_0000, 2, 0);
        run_job("srl4",    0, 3'b001, 64'h8000_0000, 8'd4,  64'h0800_0000, 2, 0);
        run_job("sra6pos", 0, 3'b010, 64'h7000_0000, 8'd6,  64'h01C0_0000, 3, 0);
        run_job("ror4",    0, 3'b100, 64'h0000_00F1, 8'd4,  64'h1000_000F, 2, 0);
        run_job("rol1",    0, 3'b011, 64'h8000_0001, 8'd1,  64'h0000_0003, 2, 0);
        run_job("rol5",    0, 3'b011, 64'h8000_0001, 8'd5,  64'h0000_0030, 3, 0);
        run_job("sll0",    0, 3'b000, 64'hDEAD_BEEF, 8'd0,  64'hDEAD_BEEF, 1, 0);
        run_job("pass7",   0, 3'b111, 64'h1234_5678, 8'd9,  64'h1234_5678, 1, 0);
        run_job("pass5",   0, 3'b101, 64'hCAFE_0001, 8'd3,  64'hCAFE_0001, 1, 0);
        run_job("poke",    0, 3'b000, 64'h0000_0001, 8'd31, 64'h8000_0000, 9, 3);

        // Reset in the middle of a job: no done, outputs cleared
        @(negedge clk);
        op0 = 3'b000; a0 = 32'h1; amt0 = 5'd31; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("midrst.busy", {63'h0, busy0}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.ready", {63'h0, ready0}, 64'h1);
        check("midrst.out",   {32'h0, out0},   64'h0);
        check("midrst.done",  {63'h0, done0},  64'h0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check("midrst.nodone", 64'(ndone), 64'h0);

        run_job("w36.sra35", 1, 3'b010, 64'h8_0000_0000, 8'd35, 64'hF_FFFF_FFFF, 36, 0);
        run_job("w36.sll40", 1, 3'b000, 64'h0_0000_0001, 8'd40, 64'h0,           41, 0);
        run_job("w36.rol37", 1, 3'b011, 64'h8_0000_0001, 8'd37, 64'h0_0000_0003, 38, 0);

        // Back-to-back: start held through DONE is taken in the next IDLE cycle
        @(negedge clk);
        op1 = 3'b010; a1 = 36'h8_0000_0000; amt1 = 6'd35; start1 = 1'b1;
        got = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done1) begin
                got = c;
                check("b2b.out1", {28'h0, out1}, 64'hF_FFFF_FFFF);
                op1 = 3'b000; a1 = 36'h1; amt1 = 6'd3;
                break;
            end
        end
        check("b2b.lat1", 64'(got), 64'd36);
        @(negedge clk);
        check("b2b.idle_ready", {63'h0, ready1}, 64'h1);
        check("b2b.idle_hold",  {28'h0, out1},   64'hF_FFFF_FFFF);
        @(posedge clk);
        #1 start1 = 1'b0;
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done1) begin
                got = c;
                check("b2b.out2", {28'h0, out1}, 64'h8);
                break;
            end
        end
        check("b2b.lat2", 64'(got), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
